hazard_tracker: RTL and testbench
=================================

# hazard_tracker

Producer-side hazard tracker for the 5-stage MIPS pipeline: it records each issued instruction's write-back register and Tnew (cycles until its result exists) as that instruction moves through E, M and W. It drives the D-stage stall and the per-stage `generated`/`WrReg`/`RegWr` signals that the forwarding mux-select logic consumes. It also owns the multi-cycle mult/div busy counter, so any HI/LO-touching instruction is held in D while the unit is occupied. Sits beside the D-stage decoder.

## Interface
- `MULT_CYC`, 5, busy cycles after a mult-class op leaves E
- `DIV_CYC`, 10, busy cycles after a div-class op leaves E

Ports:
- `clk`  in  1  pipeline clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ReReg1_D`  in  5  D-stage rs
- `ReReg2_D`  in  5  D-stage rt
- `Tuse_rs_D`  in  2  cycles until rs is needed; 3 = not read
- `Tuse_rt_D`  in  2  cycles until rt is needed; 3 = not read
- `WrReg_D`  in  5  D-stage destination register
- `RegWr_D`  in  1  D-stage instruction writes the GPR file
- `Tnew_D`  in  2  Tnew on entering E (ALU 1, load 2, link 0)
- `md_op_D`  in  2  00 none, 01 mult/multu, 10 div/divu
- `md_use_D`  in  1  D-stage instruction uses the md unit or HI/LO
- `stall`  out  1  hold PC and F/D, bubble into E
- `WrReg_E`, `WrReg_M`, `WrReg_W`  out  5 each  tracked destination registers
- `RegWr_E`, `RegWr_M`, `RegWr_W`  out  1 each  entry valid and writes
- `generated_E`, `generated_M`, `generated_W`  out  1 each  entry's result value exists (Tnew == 0)
- `md_busy`  out  1  md counter nonzero

## Operation
- Three entry registers E, M, W. Each entry holds {RegWr, WrReg, Tnew}; the E entry also holds `md_op`.
- Every rising edge:
  - W <= M with Tnew forced to 0.
  - M <= E with Tnew = max(Tnew_E − 1, 0).
  - E <= D fields when `stall`=0; otherwise E <= bubble (RegWr=0, WrReg=0, Tnew=0, md_op=00).
- `generated_X` = `RegWr_X` && (Tnew_X == 0). `generated_W` equals `RegWr_W`.
- An entry with WrReg == 0 is tracked, but it never causes a stall.
- rs stall: `ReReg1_D` != 0 && `Tuse_rs_D` != 3 && one of:
  - (`RegWr_E` && `WrReg_E` == rs && Tnew_E > `Tuse_rs_D`)
  - (`RegWr_M` && `WrReg_M` == rs && Tnew_M > `Tuse_rs_D`)
- rt stall: same rule using `ReReg2_D` and `Tuse_rt_D`.
- md stall: `md_use_D` && (`md_busy` || md_op_E != 00).
- `stall` = rs stall | rt stall | md stall. It is combinational from the D inputs and the registered state.
- md counter, width ceil(log2(DIV_CYC+1)):
  - When md_op_E is 01 it loads `MULT_CYC`; when md_op_E is 10 it loads `DIV_CYC`.
  - Otherwise it decrements while nonzero.
  - A load takes priority over the decrement. A load cannot occur while the counter is nonzero, because the md stall prevents it.
- Tnew arithmetic saturates at 0 and never wraps.

## Timing
- Reset (`rst_n`=0, takes effect immediately without waiting for a clock edge): every entry is cleared to RegWr=0, WrReg=0, Tnew=0, md_op=00. The md counter is 0. All outputs are 0, including `stall`.
- Reset asserted mid-stall or mid-md-op discards all tracked state. The first edge after release behaves as an empty pipeline.
- Latency: D fields appear on the `_E` outputs 1 edge after issue, on `_M` after 2 edges, on `_W` after 3 edges.
- Load-use case: a load (Tnew_D=2) followed by a consumer with Tuse=0 gives 2 stall cycles. With Tuse=1 it gives 1 stall cycle.
- Mult in E at edge k: `md_busy` is high for cycles k+1 … k+MULT_CYC. A dependent mfhi issues on the first edge where the counter is 0.
- Simultaneous hazards: the stall terms are OR-ed, and the cycle count is the maximum over the individual causes. Stall never lasts longer than max(Tnew)+DIV_CYC cycles.

## Test plan
- Reset: drive `rst_n`=0 mid-stream -> all outputs 0 asynchronously. After release, `addu $3` issues with no stall.
- ALU back-to-back: `addu $8` (Tnew 1) then `beq` reading $8 (Tuse 0) -> `stall`=1 for exactly 1 cycle. Then `generated_M`=1 and `WrReg_M`=8.
- Load-use: `lw $9` (Tnew 2) then `addu` reading $9 as rt (Tuse 1) -> 1 stall cycle. Changing the consumer's Tuse to 0 gives 2 stall cycles.
- $0 and Tuse=3: `lw $0`, followed by a reader of $0 and by an instruction whose Tuse is 3 for the matching register -> `stall` never asserts.
- md unit: `mult` then `mfhi` with MULT_CYC=5 -> `stall`=1 for 6 cycles (1 cycle with the op in E, then 5 busy). Repeating with `div` gives 11 stall cycles.
- Combined hazard: `lw $4`, then `div`, then `mflo $5` reading no GPR, then `addu` reading $4 -> stall cycles match the max-rule. No entry is duplicated or dropped across the bubbles.

Source files
------------

// File: rtl/hazard_tracker_if.sv
// D-stage request and tracked-stage status bundle between the decoder and hazard_tracker.
// The master drives the D-stage fields; the slave (tracker) returns stall and per-stage state.
interface hazard_tracker_if;
  logic [4:0] ReReg1_D;
  logic [4:0] ReReg2_D;
  logic [1:0] Tuse_rs_D;
  logic [1:0] Tuse_rt_D;
  logic [4:0] WrReg_D;
  logic       RegWr_D;
  logic [1:0] Tnew_D;
  logic [1:0] md_op_D;
  logic       md_use_D;

  logic       stall;
  logic [4:0] WrReg_E;
  logic [4:0] WrReg_M;
  logic [4:0] WrReg_W;
  logic       RegWr_E;
  logic       RegWr_M;
  logic       RegWr_W;
  logic       generated_E;
  logic       generated_M;
  logic       generated_W;
  logic       md_busy;

  modport master (
    output ReReg1_D, ReReg2_D, Tuse_rs_D, Tuse_rt_D, WrReg_D, RegWr_D, Tnew_D, md_op_D, md_use_D,
    input  stall, WrReg_E, WrReg_M, WrReg_W, RegWr_E, RegWr_M, RegWr_W,
           generated_E, generated_M, generated_W, md_busy
  );

  modport slave (
    input  ReReg1_D, ReReg2_D, Tuse_rs_D, Tuse_rt_D, WrReg_D, RegWr_D, Tnew_D, md_op_D, md_use_D,
    output stall, WrReg_E, WrReg_M, WrReg_W, RegWr_E, RegWr_M, RegWr_W,
           generated_E, generated_M, generated_W, md_busy
  );
endinterface

// File: rtl/hazard_tracker.sv
// Producer-side hazard tracker: follows each issued write-back through E/M/W with its Tnew,
// raises the D-stage stall on Tnew/Tuse conflicts and owns the mult/div busy counter.
module hazard_tracker #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input logic             clk,
  input logic             rst_n,
  hazard_tracker_if.slave hz
);

  localparam int CntW = $clog2(DIV_CYC + 1);
  localparam logic [1:0] MdNone = 2'b00;
  localparam logic [1:0] MdMult = 2'b01;
  localparam logic [1:0] MdDiv  = 2'b10;

  logic            regWrE, regWrM, regWrW;
  logic [4:0]      wrRegE, wrRegM, wrRegW;
  logic [1:0]      tnewE, tnewM;
  logic [1:0]      mdOpE;
  logic [CntW-1:0] mdCnt;
  logic            rsStall, rtStall, mdStall, stallInt;

  // W never needs a Tnew: anything reaching W has its value by definition.
  always_comb begin
    rsStall = (hz.ReReg1_D != 5'd0) && (hz.Tuse_rs_D != 2'd3) &&
              ((regWrE && (wrRegE == hz.ReReg1_D) && (tnewE > hz.Tuse_rs_D)) ||
               (regWrM && (wrRegM == hz.ReReg1_D) && (tnewM > hz.Tuse_rs_D)));
    rtStall = (hz.ReReg2_D != 5'd0) && (hz.Tuse_rt_D != 2'd3) &&
              ((regWrE && (wrRegE == hz.ReReg2_D) && (tnewE > hz.Tuse_rt_D)) ||
               (regWrM && (wrRegM == hz.ReReg2_D) && (tnewM > hz.Tuse_rt_D)));
    mdStall  = hz.md_use_D && ((mdCnt != '0) || (mdOpE != MdNone));
    stallInt = rsStall || rtStall || mdStall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regWrE <= 1'b0;
      wrRegE <= 5'd0;
      tnewE  <= 2'd0;
      mdOpE  <= MdNone;
      regWrM <= 1'b0;
      wrRegM <= 5'd0;
      tnewM  <= 2'd0;
      regWrW <= 1'b0;
      wrRegW <= 5'd0;
    end else begin
      regWrW <= regWrM;
      wrRegW <= wrRegM;
      regWrM <= regWrE;
      wrRegM <= wrRegE;
      tnewM  <= (tnewE == 2'd0) ? 2'd0 : tnewE - 2'd1;
      if (stallInt) begin
        regWrE <= 1'b0;
        wrRegE <= 5'd0;
        tnewE  <= 2'd0;
        mdOpE  <= MdNone;
      end else begin
        regWrE <= hz.RegWr_D;
        wrRegE <= hz.WrReg_D;
        tnewE  <= hz.Tnew_D;
        mdOpE  <= hz.md_op_D;
      end
    end
  end

  // The counter starts as the op leaves E; the md stall guarantees it is idle at that point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdCnt <= '0;
    end else if (mdOpE == MdMult) begin
      mdCnt <= CntW'(MULT_CYC);
    end else if (mdOpE == MdDiv) begin
      mdCnt <= CntW'(DIV_CYC);
    end else if (mdCnt != '0) begin
      mdCnt <= mdCnt - CntW'(1);
    end
  end

  assign hz.stall       = stallInt;
  assign hz.RegWr_E     = regWrE;
  assign hz.RegWr_M     = regWrM;
  assign hz.RegWr_W     = regWrW;
  assign hz.WrReg_E     = wrRegE;
  assign hz.WrReg_M     = wrRegM;
  assign hz.WrReg_W     = wrRegW;
  assign hz.generated_E = regWrE && (tnewE == 2'd0);
  assign hz.generated_M = regWrM && (tnewM == 2'd0);
  assign hz.generated_W = regWrW;
  assign hz.md_busy     = (mdCnt != '0);

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed and random checks of hazard_tracker against a model that tracks each issued
// instruction by its issue time and derives stage, Tnew and md busy from elapsed edges.
module tb_hazard_tracker;

  logic clk = 1'b0;
  logic rst_n;
  int   nCompared = 0;
  int   nFailed   = 0;
  int   edgeCount = 0;

  hazard_tracker_if hz();

  hazard_tracker #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       regWr;
    logic [4:0] wrReg;
    int         tnew0;
    int         mdOp;
    int         issueEdge;
  } issued_t;

  issued_t inflight[$];
  int      mdIssueEdge = 0;
  int      mdLen       = 0;

  // age 0 = issued at the latest edge (E), 1 = M, 2 = W.
  function automatic bit stageEntry(input int age, output issued_t r);
    r = '{default: 0};
    foreach (inflight[i])
      if (inflight[i].issueEdge == edgeCount - age) begin
        r = inflight[i];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic int tnewAt(input issued_t r, input int age);
    if (age >= 2) return 0;
    return (r.tnew0 - age < 0) ? 0 : r.tnew0 - age;
  endfunction

  function automatic bit readBlocked(input logic [4:0] src, input logic [1:0] tuse);
    issued_t r;
    if (src == 5'd0 || tuse == 2'd3) return 1'b0;
    for (int age = 0; age < 2; age++)
      if (stageEntry(age, r) && r.regWr && r.wrReg == src && tnewAt(r, age) > int'(tuse))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit mdBusyModel();
    return mdLen > 0 && edgeCount > mdIssueEdge && edgeCount <= mdIssueEdge + mdLen;
  endfunction

  function automatic bit stallModel();
    issued_t r;
    bit      mdInE;
    mdInE = stageEntry(0, r) && r.mdOp != 0;
    return readBlocked(hz.ReReg1_D, hz.Tuse_rs_D) || readBlocked(hz.ReReg2_D, hz.Tuse_rt_D) ||
           (hz.md_use_D && (mdBusyModel() || mdInE));
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp)
    else begin
      nFailed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkStage(input string name, input int age, input logic regWr,
                            input logic [4:0] wr, input logic gen);
    issued_t r;
    bit      found;
    logic    expRegWr;
    found    = stageEntry(age, r);
    expRegWr = found && r.regWr;
    cmp({"RegWr_", name}, 32'(regWr), 32'(expRegWr));
    cmp({"WrReg_", name}, 32'(wr), found ? 32'(r.wrReg) : 32'd0);
    cmp({"generated_", name}, 32'(gen), 32'(expRegWr && tnewAt(r, age) == 0));
  endtask

  task automatic checkOutput();
    cmp("stall", 32'(hz.stall), 32'(stallModel()));
    cmp("md_busy", 32'(hz.md_busy), 32'(mdBusyModel()));
    checkStage("E", 0, hz.RegWr_E, hz.WrReg_E, hz.generated_E);
    checkStage("M", 1, hz.RegWr_M, hz.WrReg_M, hz.generated_M);
    checkStage("W", 2, hz.RegWr_W, hz.WrReg_W, hz.generated_W);
  endtask

  task automatic applyStimulus(input logic [4:0] r1, input logic [4:0] r2, input logic [1:0] tu1,
                               input logic [1:0] tu2, input logic [4:0] wr, input logic regWr,
                               input logic [1:0] tnew, input logic [1:0] mdOp, input logic mdUse);
    hz.ReReg1_D  = r1;
    hz.ReReg2_D  = r2;
    hz.Tuse_rs_D = tu1;
    hz.Tuse_rt_D = tu2;
    hz.WrReg_D   = wr;
    hz.RegWr_D   = regWr;
    hz.Tnew_D    = tnew;
    hz.md_op_D   = mdOp;
    hz.md_use_D  = mdUse;
  endtask

  task automatic tick();
    bit      s;
    issued_t r;
    s       = stallModel();
    r.regWr = hz.RegWr_D;
    r.wrReg = hz.WrReg_D;
    r.tnew0 = int'(hz.Tnew_D);
    r.mdOp  = int'(hz.md_op_D);
    @(posedge clk);
    edgeCount++;
    r.issueEdge = edgeCount;
    if (!s) begin
      inflight.push_back(r);
      if (r.mdOp == 1) begin
        mdIssueEdge = edgeCount;
        mdLen       = 5;
      end else if (r.mdOp == 2) begin
        mdIssueEdge = edgeCount;
        mdLen       = 10;
      end
    end
    while (inflight.size() > 0 && inflight[0].issueEdge < edgeCount - 2) void'(inflight.pop_front());
    #1;
  endtask

  task automatic runInstr(input logic [4:0] r1, input logic [4:0] r2, input logic [1:0] tu1,
                          input logic [1:0] tu2, input logic [4:0] wr, input logic regWr,
                          input logic [1:0] tnew, input logic [1:0] mdOp, input logic mdUse,
                          input int expStalls, input string tag);
    int seen = 0;
    bit s;
    applyStimulus(r1, r2, tu1, tu2, wr, regWr, tnew, mdOp, mdUse);
    for (int i = 0; i < 40; i++) begin
      #1;
      checkOutput();
      s = stallModel();
      if (hz.stall === 1'b1) seen++;
      tick();
      if (!s) break;
    end
    cmp(tag, 32'(seen), 32'(expStalls));
  endtask

  task automatic drain(input int n);
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    for (int i = 0; i < n; i++) begin
      #1;
      checkOutput();
      tick();
    end
  endtask

  task automatic doResetCheck(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    cmp({tag, "_stall"}, 32'(hz.stall), 32'd0);
    cmp({tag, "_md_busy"}, 32'(hz.md_busy), 32'd0);
    cmp({tag, "_stage_bits"}, 32'({hz.RegWr_E, hz.RegWr_M, hz.RegWr_W,
                                  hz.generated_E, hz.generated_M, hz.generated_W}), 32'd0);
    cmp({tag, "_wrregs"}, 32'({hz.WrReg_E, hz.WrReg_M, hz.WrReg_W}), 32'd0);
    @(posedge clk);
    edgeCount++;
    #1;
    inflight.delete();
    mdLen = 0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [1:0] mdOp;
    rst_n = 1'b0;
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    doResetCheck("rst_init");

    runInstr(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 1'b1, 2'd1, 2'd0, 1'b0, 0, "addu3_after_reset");
    drain(3);

    runInstr(5'd1, 5'd2, 2'd1, 2'd1, 5'd8, 1'b1, 2'd1, 2'd0, 1'b0, 0, "addu8_issue");
    runInstr(5'd8, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1, "beq_after_addu");
    cmp("addu8_in_W", 32'(hz.WrReg_W), 32'd8);
    drain(3);

    runInstr(5'd1, 5'd0, 2'd1, 2'd3, 5'd9, 1'b1, 2'd2, 2'd0, 1'b0, 0, "lw9_issue");
    runInstr(5'd2, 5'd9, 2'd1, 2'd1, 5'd10, 1'b1, 2'd1, 2'd0, 1'b0, 1, "loaduse_tuse1");
    drain(3);
    runInstr(5'd1, 5'd0, 2'd1, 2'd3, 5'd9, 1'b1, 2'd2, 2'd0, 1'b0, 0, "lw9_issue2");
    runInstr(5'd2, 5'd9, 2'd1, 2'd0, 5'd10, 1'b1, 2'd1, 2'd0, 1'b0, 2, "loaduse_tuse0");
    drain(3);

    runInstr(5'd1, 5'd0, 2'd1, 2'd3, 5'd0, 1'b1, 2'd2, 2'd0, 1'b0, 0, "lw0_issue");
    runInstr(5'd0, 5'd0, 2'd0, 2'd0, 5'd11, 1'b1, 2'd1, 2'd0, 1'b0, 0, "reader_of_r0");
    drain(3);
    runInstr(5'd1, 5'd0, 2'd1, 2'd3, 5'd9, 1'b1, 2'd2, 2'd0, 1'b0, 0, "lw9_issue3");
    runInstr(5'd9, 5'd9, 2'd3, 2'd3, 5'd11, 1'b1, 2'd1, 2'd0, 1'b0, 0, "tuse3_no_read");
    drain(3);

    runInstr(5'd4, 5'd5, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0, 2'd1, 1'b1, 0, "mult_issue");
    runInstr(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 1'b1, 2'd1, 2'd0, 1'b1, 6, "mfhi_after_mult");
    drain(3);
    runInstr(5'd4, 5'd5, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0, 2'd2, 1'b1, 0, "div_issue");
    runInstr(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 1'b1, 2'd1, 2'd0, 1'b1, 11, "mflo_after_div");
    drain(3);

    runInstr(5'd1, 5'd0, 2'd1, 2'd3, 5'd4, 1'b1, 2'd2, 2'd0, 1'b0, 0, "combo_lw4");
    runInstr(5'd6, 5'd7, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0, 2'd2, 1'b1, 0, "combo_div");
    runInstr(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 1'b1, 2'd1, 2'd0, 1'b1, 11, "combo_mflo5");
    runInstr(5'd4, 5'd0, 2'd0, 2'd0, 5'd12, 1'b1, 2'd1, 2'd0, 1'b0, 0, "combo_addu_r4");
    drain(3);

    // Reset while an mfhi waits on a busy mult: the pending md work must be forgotten.
    runInstr(5'd4, 5'd5, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0, 2'd1, 1'b1, 0, "mult_before_reset");
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 1'b1, 2'd1, 2'd0, 1'b1);
    #1;
    checkOutput();
    tick();
    checkOutput();
    tick();
    doResetCheck("rst_mid_md");
    runInstr(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 1'b1, 2'd1, 2'd0, 1'b1, 0, "mfhi_after_reset");

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       mdOp = 2'b01;
        1:       mdOp = 2'b10;
        default: mdOp = 2'b00;
      endcase
      applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 2)), mdOp,
                    (mdOp != 2'b00) || ($urandom_range(0, 3) == 0));
      #1;
      checkOutput();
      tick();
      if (i == 150 || i == 300) doResetCheck("rst_random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
